// File: rtl/aes_enc_stream_host_if.sv
// Host-side valid/ready bundle for aes_enc_stream_host: one request channel
// carrying key + plaintext, one response channel carrying the ciphertext word.
interface aes_enc_stream_host_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_key;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;

   // System-side view: issues requests, consumes ciphertext.
   modport master (
      output in_valid, in_key, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   // Adapter-side view.
   modport slave (
      input  in_valid, in_key, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/aes_enc_stream_host.sv
// aes_enc_stream_host: takes a 128-bit key/plaintext pair, feeds it byte-serially
// (byte 0 = MSB) to the AES_encryption core, collects the 16 ciphertext bytes the
// core streams back and holds them as one 128-bit word until the host takes it.
// A progress watchdog aborts a stalled transaction and pulses err_timeout.
module aes_enc_stream_host #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   aes_enc_stream_host_if.slave host,
   output logic                 err_timeout,
   output logic                 busy,
   output logic                 core_enable,
   output logic [7:0]           core_key_byte,
   output logic [7:0]           core_state_byte,
   input  logic                 core_load,
   input  logic                 core_ready,
   input  logic [7:0]           core_out_byte
);

   localparam int            TW        = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TW-1:0] TC_LAST   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [4:0]    LAST_BEAT = 5'd15;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FEED    = 2'd1,
      S_COLLECT = 2'd2,
      S_HOLD    = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [127:0]  key_sr_q, key_sr_d;
   logic [127:0]  dat_sr_q, dat_sr_d;
   // Only 15 bytes need buffering: the 16th arrives on the completing edge.
   logic [119:0]  out_sr_q, out_sr_d;
   logic [127:0]  out_data_q, out_data_d;
   logic [4:0]    bcnt_q, bcnt_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          err_q, err_d;
   logic          tmo_hit;

   assign tmo_hit = (tcnt_q == TC_LAST);

   // Next-state, datapath shift and watchdog decisions.
   always_comb begin
      state_d    = state_q;
      key_sr_d   = key_sr_q;
      dat_sr_d   = dat_sr_q;
      out_sr_d   = out_sr_q;
      out_data_d = out_data_q;
      bcnt_d     = bcnt_q;
      tcnt_d     = tcnt_q;
      err_d      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // in_ready is high for the whole of IDLE, so valid alone completes the handshake.
            if (host.in_valid) begin
               key_sr_d = host.in_key;
               dat_sr_d = host.in_data;
               bcnt_d   = 5'd0;
               tcnt_d   = '0;
               state_d  = S_FEED;
            end
         end

         S_FEED: begin
            if (core_load) begin
               key_sr_d = {key_sr_q[119:0], 8'h00};
               dat_sr_d = {dat_sr_q[119:0], 8'h00};
               tcnt_d   = '0;
               if (bcnt_q == LAST_BEAT) begin
                  bcnt_d  = 5'd0;
                  state_d = S_COLLECT;
               end else begin
                  bcnt_d = bcnt_q + 5'd1;
               end
            end else if (tmo_hit) begin
               err_d   = 1'b1;
               tcnt_d  = '0;
               bcnt_d  = 5'd0;
               state_d = S_IDLE;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end

         S_COLLECT: begin
            if (core_ready) begin
               out_sr_d = {out_sr_q[111:0], core_out_byte};
               tcnt_d   = '0;
               if (bcnt_q == LAST_BEAT) begin
                  out_data_d = {out_sr_q, core_out_byte};
                  bcnt_d     = 5'd0;
                  state_d    = S_HOLD;
               end else begin
                  bcnt_d = bcnt_q + 5'd1;
               end
            end else if (tmo_hit) begin
               err_d   = 1'b1;
               tcnt_d  = '0;
               bcnt_d  = 5'd0;
               state_d = S_IDLE;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end

         S_HOLD: begin
            if (host.out_ready) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset returns everything to an empty IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         key_sr_q   <= '0;
         dat_sr_q   <= '0;
         out_sr_q   <= '0;
         out_data_q <= '0;
         bcnt_q     <= 5'd0;
         tcnt_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         key_sr_q   <= key_sr_d;
         dat_sr_q   <= dat_sr_d;
         out_sr_q   <= out_sr_d;
         out_data_q <= out_data_d;
         bcnt_q     <= bcnt_d;
         tcnt_q     <= tcnt_d;
         err_q      <= err_d;
      end
   end

   // Outputs are pure decodes of registered state so nothing combinational reaches the ports.
   assign host.in_ready   = (state_q == S_IDLE);
   assign host.out_valid  = (state_q == S_HOLD);
   assign host.out_data   = out_data_q;
   assign busy            = (state_q == S_FEED) || (state_q == S_COLLECT);
   assign core_enable     = busy;
   assign core_key_byte   = (state_q == S_FEED) ? key_sr_q[127:120] : 8'h00;
   assign core_state_byte = (state_q == S_FEED) ? dat_sr_q[127:120] : 8'h00;
   assign err_timeout     = err_q;

endmodule
